// File: rtl/dmem_responder_if.sv
// ----------------------------------------------------------------------------
// dmem_responder_if
// Bundles the request/response handshake between the memory stage (master)
// and the multi-cycle data-memory responder (slave).
//   flush      : cancel any in-flight response, blocks acceptance while high
//   req_valid  : request present
//   req_wr     : 1 = store, 0 = load
//   req_addr   : word address (low bits decoded by the responder)
//   req_wdata  : store data
//   req_ready  : responder can accept this cycle
//   rsp_valid  : one-cycle response pulse
//   rsp_wr     : 1 = store acknowledge, 0 = load data
//   rsp_rdata  : load data
//   busy       : request in flight
// ----------------------------------------------------------------------------
interface dmem_responder_if;
    logic        flush;
    logic        req_valid;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_wr;
    logic [15:0] rsp_rdata;
    logic        busy;

    modport master (
        output flush, req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_wr, rsp_rdata, busy
    );

    modport slave (
        input  flush, req_valid, req_wr, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_wr, rsp_rdata, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Multi-cycle data memory seen from the pipeline's memory stage. One request
// is accepted at a time; stores commit on the acceptance edge, loads sample
// the array on the acceptance edge, and the response (load data or store
// acknowledge) appears LATENCY edges after acceptance. A flush cancels any
// response still in flight.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : dmem_responder_if.slave (request/response handshake, flush, busy)
// Parameters:
//   ADDR_W  : decoded word-address bits (2^ADDR_W x 16-bit words)
//   LATENCY : edges from acceptance to response, 1..15
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // Countdown preload for WAIT; unused when LATENCY == 1.
    localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 2);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [15:0]        mem [2**ADDR_W];
    logic               pend_wr_q;
    logic [15:0]        pend_rdata_q;
    logic               rsp_wr_q;
    logic [15:0]        rsp_rdata_q;

    logic [ADDR_W-1:0]  idx;
    logic               accept;
    logic [15:0]        acc_rdata;
    logic               load_rsp;
    logic               unused_addr;

    // Upper address bits alias onto the decoded range.
    assign idx         = bus.req_addr[ADDR_W-1:0];
    assign unused_addr = ^bus.req_addr[15:ADDR_W];

    assign bus.req_ready = !bus.flush && (state_q == IDLE || state_q == RESP);
    // Nothing is accepted while reset is held, so the array is never
    // written during reset even though req_ready reads 1.
    assign accept        = bus.req_valid && bus.req_ready && rst;
    assign acc_rdata     = bus.req_wr ? 16'h0000 : mem[idx];

    // Flush gates the response pulse combinationally in the same cycle.
    assign bus.rsp_valid = (state_q == RESP) && !bus.flush;
    assign bus.rsp_wr    = rsp_wr_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.busy      = (state_q != IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.flush && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else if (accept) begin
            if (LATENCY == 1) begin
                state_d = RESP;
            end else begin
                state_d = WAIT;
                cnt_d   = WAIT_INIT;
            end
        end else begin
            case (state_q)
                WAIT: begin
                    if (cnt_q == 4'd0) state_d = RESP;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                RESP:    state_d = IDLE;
                default: ;
            endcase
        end
    end

    // Output registers load on the edge that enters RESP, so rsp_wr and
    // rsp_rdata hold their previous values while no response is showing.
    assign load_rsp = (state_d == RESP);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            pend_wr_q    <= 1'b0;
            pend_rdata_q <= 16'h0000;
            rsp_wr_q     <= 1'b0;
            rsp_rdata_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                pend_wr_q    <= bus.req_wr;
                pend_rdata_q <= acc_rdata;
            end
            if (load_rsp) begin
                rsp_wr_q    <= accept ? bus.req_wr : pend_wr_q;
                rsp_rdata_q <= accept ? acc_rdata  : pend_rdata_q;
            end
        end
    end

    // NOTE: the array has no reset; contents survive reset and flush, and a
    // reset port here would turn the RAM into a large register file.
    always_ff @(posedge clk) begin
        if (accept && bus.req_wr) mem[idx] <= bus.req_wdata;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
// Two responders (LATENCY=2 and LATENCY=1) share one stimulus driver selected
// by 'sel'. Each has a reference model that tracks "a response is due at
// cycle N" plus a plain word array, and a compare process that checks every
// output on every falling edge. Directed sequences add literal expectations.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        sel;
    logic        drv_valid, drv_wr, drv_flush;
    logic [15:0] drv_addr, drv_wdata;

    logic [1:0]  obs_ready, obs_valid, obs_wr, obs_busy;
    logic [15:0] obs_rdata [2];

    int n_cmp = 0;
    int n_bad = 0;
    int tcyc  = 0;
    always @(posedge clk) tcyc <= tcyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int   L  = (g == 0) ? 2 : 1;
        localparam logic ME = 1'(g);

        dmem_responder_if bus();
        dmem_responder #(.ADDR_W(8), .LATENCY(L)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

        assign bus.req_valid = (sel == ME) ? drv_valid : 1'b0;
        assign bus.flush     = (sel == ME) ? drv_flush : 1'b0;
        assign bus.req_wr    = drv_wr;
        assign bus.req_addr  = drv_addr;
        assign bus.req_wdata = drv_wdata;
        assign obs_ready[g]  = bus.req_ready;
        assign obs_valid[g]  = bus.rsp_valid;
        assign obs_wr[g]     = bus.rsp_wr;
        assign obs_busy[g]   = bus.busy;
        assign obs_rdata[g]  = bus.rsp_rdata;

        // Reference model: pending response due at absolute cycle 'due'.
        bit [15:0] mmem [256];
        bit        pend = 1'b0;
        int        now  = 0;
        int        due  = 0;
        bit        ew   = 1'b0;
        bit [15:0] ed   = 16'h0000;
        bit        lw   = 1'b0;
        bit [15:0] ld   = 16'h0000;

        initial forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                pend = 1'b0;
                lw   = 1'b0;
                ld   = 16'h0000;
            end else begin
                bit rdy, acc, resp_now;
                bit [7:0] a;
                rdy      = !bus.flush && (!pend || now == due);
                acc      = bus.req_valid && rdy;
                resp_now = pend && now == due;
                now++;
                if (bus.flush && pend) begin
                    pend = 1'b0;
                end else if (acc) begin
                    a = bus.req_addr[7:0];
                    if (bus.req_wr) mmem[a] = bus.req_wdata;
                    ew   = bus.req_wr;
                    ed   = bus.req_wr ? 16'h0000 : mmem[a];
                    pend = 1'b1;
                    due  = now + L - 1;
                end else if (resp_now) begin
                    pend = 1'b0;
                end
                if (pend && now == due) begin
                    lw = ew;
                    ld = ed;
                end
            end
        end

        initial forever begin
            bit er, ev;
            @(negedge clk);
            er = !bus.flush && (!pend || now == due);
            ev = pend && now == due && !bus.flush;
            check($sformatf("L%0d req_ready", L), bus.req_ready, er);
            check($sformatf("L%0d rsp_valid", L), bus.rsp_valid, ev);
            check($sformatf("L%0d busy", L), bus.busy, pend);
            check($sformatf("L%0d rsp_rdata", L), bus.rsp_rdata, ld);
            if (ev && bus.rsp_valid) check($sformatf("L%0d rsp_wr", L), bus.rsp_wr, lw);
        end
    end

    task automatic idle();
        drv_valid = 1'b0; drv_wr = 1'b0; drv_flush = 1'b0;
        drv_addr  = 16'h0000; drv_wdata = 16'h0000;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (obs_ready[sel]) return;
        end
        check("ready timeout", 16'd0, 16'd1);
    endtask

    task automatic do_req(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                          output int acc);
        drv_valid = 1'b1; drv_wr = wr; drv_addr = addr; drv_wdata = wdata;
        wait_ready();
        @(posedge clk); #1;
        acc = tcyc;
        drv_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int rc, output logic [15:0] d, output logic w);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (obs_valid[sel]) begin
                rc = tcyc; d = obs_rdata[sel]; w = obs_wr[sel];
                return;
            end
        end
        check("rsp timeout", 16'd0, 16'd1);
        rc = -1000; d = 16'hxxxx; w = 1'bx;
    endtask

    task automatic txn(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                       output logic [15:0] d, output logic w, output int lat);
        int acc, rc;
        do_req(wr, addr, wdata, acc);
        wait_rsp(rc, d, w);
        lat = rc - acc;
    endtask

    initial begin
        logic [15:0] d;
        logic        w;
        int          lat, acc, t1, t2;

        sel = 1'b0;
        idle();
        rst = 1'b0;
        #12;
        for (int s = 0; s < 2; s++) begin
            check("reset rsp_valid", obs_valid[s], 16'd0);
            check("reset rsp_wr",    obs_wr[s],    16'd0);
            check("reset rsp_rdata", obs_rdata[s], 16'h0000);
            check("reset busy",      obs_busy[s],  16'd0);
            check("reset req_ready", obs_ready[s], 16'd1);
        end
        #10 rst = 1'b1;
        @(posedge clk); #1;

        // Fill both arrays so every later load has a known value.
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int a = 0; a < 256; a++) txn(1'b1, 16'(a), 16'($urandom), d, w, lat);
        end

        // Reset while a load waits in WAIT.
        sel = 1'b0;
        @(posedge clk); #1;
        do_req(1'b0, 16'h0003, 16'h0000, acc);
        rst = 1'b0;
        #1;
        check("rstwait busy",      obs_busy[0],  16'd0);
        check("rstwait rsp_valid", obs_valid[0], 16'd0);
        check("rstwait rsp_rdata", obs_rdata[0], 16'h0000);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstwait no rsp", obs_valid[0], 16'd0);
            check("rstwait ready",  obs_ready[0], 16'd1);
        end

        // LATENCY=2 store then load.
        txn(1'b1, 16'h0012, 16'hBEEF, d, w, lat);
        check("st lat", 16'(lat), 16'd1);
        check("st rsp_wr", w, 16'd1);
        check("st rdata", d, 16'h0000);
        txn(1'b0, 16'h0012, 16'h0000, d, w, lat);
        check("ld lat", 16'(lat), 16'd1);
        check("ld rsp_wr", w, 16'd0);
        check("ld rdata", d, 16'hBEEF);

        // Back-to-back loads accepted in the RESP cycle.
        txn(1'b1, 16'h0001, 16'h1111, d, w, lat);
        txn(1'b1, 16'h0002, 16'h2222, d, w, lat);
        drv_valid = 1'b1; drv_wr = 1'b0; drv_addr = 16'h0001;
        wait_ready();
        @(posedge clk); #1;
        drv_addr = 16'h0002;
        @(negedge clk);
        check("b2b wait1 ready", obs_ready[0], 16'd0);
        @(negedge clk);
        check("b2b rsp1 valid", obs_valid[0], 16'd1);
        check("b2b rsp1 rdata", obs_rdata[0], 16'h1111);
        t1 = tcyc;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        @(negedge clk);
        check("b2b wait2 ready", obs_ready[0], 16'd0);
        @(negedge clk);
        check("b2b rsp2 valid", obs_valid[0], 16'd1);
        check("b2b rsp2 rdata", obs_rdata[0], 16'h2222);
        t2 = tcyc;
        check("b2b spacing", 16'(t2 - t1), 16'd2);

        // Flush during WAIT.
        txn(1'b1, 16'h0005, 16'h5A5A, d, w, lat);
        do_req(1'b0, 16'h0005, 16'h0000, acc);
        drv_flush = 1'b1;
        @(negedge clk);
        check("flush gated valid", obs_valid[0], 16'd0);
        @(posedge clk); #1;
        drv_flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flush busy",   obs_busy[0],  16'd0);
            check("flush no rsp", obs_valid[0], 16'd0);
        end
        txn(1'b0, 16'h0005, 16'h0000, d, w, lat);
        check("flush readback", d, 16'h5A5A);

        // LATENCY=1 with address aliasing.
        sel = 1'b1;
        @(posedge clk); #1;
        txn(1'b1, 16'h0107, 16'h00AA, d, w, lat);
        check("l1 st lat", 16'(lat), 16'd0);
        txn(1'b0, 16'h0007, 16'h0000, d, w, lat);
        check("l1 ld lat", 16'(lat), 16'd0);
        check("l1 alias rdata", d, 16'h00AA);
        @(negedge clk);
        check("l1 busy drop", obs_busy[1], 16'd0);

        // Randomised traffic with flushes and occasional reset pulses.
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int i = 0; i < 1500; i++) begin
                @(posedge clk); #1;
                drv_valid = ($urandom_range(0, 9) < 6);
                drv_wr    = 1'($urandom);
                drv_addr  = 16'($urandom);
                drv_wdata = 16'($urandom);
                drv_flush = ($urandom_range(0, 9) == 0);
                rst       = ($urandom_range(0, 99) != 0);
            end
            @(posedge clk); #1;
            rst = 1'b1;
            idle();
            repeat (20) @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
